// File: rtl/hs_pipe_fifo.sv
// hs_pipe_fifo: elastic valid/ack FIFO with occupancy, almost-full flag and synchronous flush
module hs_pipe_fifo #(
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ack_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ack_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  always_comb begin
    empty       = count == '0;
    full        = count == CW'(DEPTH);
    almost_full = count >= CW'(AFULL_LEVEL);
    ack_out     = !full;
    valid_out   = !empty;
    push        = valid_in && ack_out;
    pop         = valid_out && ack_in;
    data_out    = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  // Storage carries no reset: contents are unobservable while empty.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= data_in;
  end
endmodule

// File: doc/hs_pipe_fifo.md
Name: hs_pipe_fifo

Overview:
- Parametrised successor to the single valid/ack combine stage: a clocked elastic FIFO of DEPTH entries with valid/ack handshakes on both sides.
- Sits between two valid/ack stages in the datapath and absorbs back-pressure from downstream without dropping words.
- Adds what the single stage lacks: depth, occupancy reporting, almost-full flag and synchronous flush.

Parameters:
- DATA_WIDTH, 3, width of data_in/data_out.
- DEPTH, 4, number of entries; power of two, >= 2.
- AFULL_LEVEL, 3, almost_full asserts when count >= AFULL_LEVEL; range 1..DEPTH.
- CW, $clog2(DEPTH+1), width of count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of all stored words.
- valid_in  in  1  upstream word valid.
- ack_out  out  1  upstream accept; high when FIFO can take a word.
- data_in  in  DATA_WIDTH  upstream word.
- valid_out  out  1  downstream word valid.
- ack_in  in  1  downstream accept.
- data_out  out  DATA_WIDTH  head word.
- count  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LEVEL.

Behaviour:
- Reset: one clock is synchronous and active-high; rst sampled high at a rising clk edge sets wr_ptr = rd_ptr = 0 and count = 0.
- Reset values: valid_out = 0, ack_out = 1, empty = 1, full = 0, almost_full = 0, count = 0. data_out has no defined reset value and must not be checked while valid_out = 0.
- Storage: register array of DEPTH words; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Push: valid_in && ack_out at the edge writes data_in to mem[wr_ptr] and increments wr_ptr.
- Pop: valid_out && ack_in at the edge increments rd_ptr.
- Handshake outputs: ack_out = !full; valid_out = !empty. Both are derived from registered count only, with no combinational path from valid_in or ack_in.
- data_out = mem[rd_ptr]. It must hold stable while valid_out = 1 and ack_in = 0.
- Latency: a word pushed at edge N is visible on valid_out/data_out after edge N; no same-cycle fall-through.
- Simultaneous push and pop (neither empty nor full): both pointers advance and count is unchanged.
- When full: ack_out = 0, so no push is possible. A pop in that cycle lowers count to DEPTH-1, and ack_out rises after the edge. There is no same-cycle pass-through.
- When empty: valid_out = 0, so no pop is possible. A push in that cycle makes count 1 and valid_out rises after the edge.
- valid_in while ack_out = 0: the word is not taken. Upstream must hold it; the FIFO does not count it as an error.
- Flush: flush high at an edge clears pointers and count exactly as rst does. Flush overrides any push or pop in the same cycle; the word offered that cycle is discarded.
- Priority: rst > flush > push/pop.
- count arithmetic: count_next = count + push - pop in CW bits. It must never exceed DEPTH or go below 0, which holds by construction of ack_out/valid_out.
- Flags are registered alongside count (or decoded from it) and must be consistent with count on every cycle.
- Reset mid-operation: all stored words are lost, and outputs return to reset values after the reset edge.

Test Plan (DATA_WIDTH=3, DEPTH=4, AFULL_LEVEL=3):
1. Reset: rst=1 for 2 edges, then 0 -> valid_out=0, ack_out=1, empty=1, count=0.
2. Fill: valid_in=1, ack_in=0, data_in=1,2,3,4,5 on consecutive edges.
   - count goes 1,2,3,4.
   - almost_full rises when count=3; full=1 and ack_out=0 when count=4.
   - Word 5 is not accepted (count stays 4).
3. Drain: valid_in=0, ack_in=1 -> data_out presents 1,2,3,4 on successive cycles, then valid_out=0 and empty=1. Ordering is preserved.
4. Steady stream: count=2, valid_in=ack_in=1 for 8 cycles with data_in=0..7 -> count stays 2 and the output sequence continues in order. Pointers wrap past index 3 with no corruption.
5. Full plus pop: FIFO full, ack_in=1 and valid_in=1 (data 6) -> first edge pops only (count=3). Next edge pushes 6 and pops, so count stays 3. 6 emerges after the older words.
6. Flush: count=3, flush=1 together with valid_in=1 (data 7) and ack_in=1 -> after the edge count=0, empty=1, valid_out=0. Word 7 is never output.
